// File: rtl/load_align_unit_pkg.sv
// -----------------------------------------------------------------------------
// load_align_unit_pkg
//   Shared types for the load alignment path.
//   - mem_op_enum     : load operation type, same encoding the MEM stage uses.
//   - load_state_enum : states of the load_align_unit sequencer.
//   - op_info_t       : access size in bytes plus a sign-extend flag.
//   - op_info()       : maps a mem_op_enum to its op_info_t (MEM_NO -> size 0).
// -----------------------------------------------------------------------------
package load_align_unit_pkg;

    typedef enum logic [2:0] {
        MEM_NO = 3'd0,
        MEM_B  = 3'd1,
        MEM_H  = 3'd2,
        MEM_W  = 3'd3,
        MEM_D  = 3'd4,
        MEM_UB = 3'd5,
        MEM_UH = 3'd6,
        MEM_UW = 3'd7
    } mem_op_enum;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REQ0  = 3'd1,
        ST_WAIT0 = 3'd2,
        ST_REQ1  = 3'd3,
        ST_WAIT1 = 3'd4,
        ST_RESP  = 3'd5
    } load_state_enum;

    typedef struct packed {
        logic [3:0] size;
        logic       is_signed;
    } op_info_t;

    function automatic op_info_t op_info(input mem_op_enum op);
        op_info_t r;
        r.size      = 4'd0;
        r.is_signed = 1'b0;
        case (op)
            MEM_B:   begin r.size = 4'd1; r.is_signed = 1'b1; end
            MEM_H:   begin r.size = 4'd2; r.is_signed = 1'b1; end
            MEM_W:   begin r.size = 4'd4; r.is_signed = 1'b1; end
            MEM_D:   begin r.size = 4'd8; r.is_signed = 1'b1; end
            MEM_UB:  r.size = 4'd1;
            MEM_UH:  r.size = 4'd2;
            MEM_UW:  r.size = 4'd4;
            default: r.size = 4'd0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/load_extract.sv
// -----------------------------------------------------------------------------
// load_extract
//   Combinational byte extraction and extension for a load that may span two
//   memory words. The two beats are concatenated {beat1, beat0}, shifted right
//   by offset bytes, truncated to size bytes and then sign- or zero-extended.
//
//   Ports:
//     beat0     in  XLEN   first (lower-address) memory word
//     beat1     in  XLEN   second memory word, zero when the load is not split
//     offset    in  log2(XLEN/8)  byte offset of the load inside beat0
//     size      in  4      access size in bytes (0 yields a zero result)
//     is_signed in  1      replicate the top accessed bit into the upper bits
//     data      out XLEN   extended result
// -----------------------------------------------------------------------------
module load_extract #(
    parameter int XLEN = 64
) (
    input  logic [XLEN-1:0]           beat0,
    input  logic [XLEN-1:0]           beat1,
    input  logic [$clog2(XLEN/8)-1:0] offset,
    input  logic [3:0]                size,
    input  logic                      is_signed,
    output logic [XLEN-1:0]           data
);

    logic [2*XLEN-1:0] window;
    logic [XLEN-1:0]   low;
    logic [XLEN-1:0]   mask;
    logic [XLEN-1:0]   top_bit;
    logic              sign;

    always_comb begin
        window = {beat1, beat0} >> {offset, 3'b000};
        low    = window[XLEN-1:0];
        mask   = '0;
        for (int i = 0; i < XLEN; i++) begin
            mask[i] = (i < 8 * int'(size));
        end
        // Highest set bit of the mask marks the sign bit of the accessed field;
        // this avoids a variable bit-select that could run past XLEN.
        top_bit = mask & ~(mask >> 1);
        sign    = is_signed && (|(low & top_bit));
        data    = (low & mask) | (sign ? ~mask : '0);
    end

endmodule

// File: rtl/load_align_unit.sv
// -----------------------------------------------------------------------------
// load_align_unit
//   Load path between the MEM stage and the data-memory port. Accepts one load,
//   fetches the aligned word (two words when the access straddles a word
//   boundary), then extracts and extends the requested bytes.
//
//   Optional build macro: MISALIGN_TRAP_EN
//     defined   : a load with addr mod size != 0 issues no memory beat and
//                 returns resp_fault=1, resp_data=0.
//     undefined : misaligned loads are serviced, split across two beats if
//                 needed.
//
//   Handshakes: every interface uses valid/ready. A transfer happens on a
//   rising clock edge where both valid and ready are high; a source holds
//   valid and its payload unchanged until that edge, and never drops valid
//   before the transfer.
//
//   Ports:
//     clk, rst        core clock, asynchronous active-high reset
//     req_valid/ready load request handshake (ready only while IDLE)
//     req_addr        byte address of the load
//     req_op          load type (mem_op_enum)
//     mem_req_*       word-aligned read request to data memory
//     mem_resp_*      read data returned by memory (no ready; always taken)
//     resp_valid/ready result handshake
//     resp_data       extended load result
//     resp_split      result needed two memory beats
//     resp_fault      illegal op (MEM_D at XLEN=32) or trapped misalignment
//     dbg_state       current sequencer state
// -----------------------------------------------------------------------------
module load_align_unit
    import load_align_unit_pkg::*;
#(
    parameter int XLEN   = 64,
    parameter int ADDR_W = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  mem_op_enum        req_op,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [ADDR_W-1:0] mem_req_addr,
    input  logic              mem_resp_valid,
    input  logic [XLEN-1:0]   mem_resp_data,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [XLEN-1:0]   resp_data,
    output logic              resp_split,
    output logic              resp_fault,
    output load_state_enum    dbg_state
);

    localparam int WB    = XLEN / 8;
    localparam int OFF_W = $clog2(WB);

    load_state_enum    state_q;
    logic [ADDR_W-1:0] base_q;
    logic [OFF_W-1:0]  off_q;
    logic [3:0]        size_q;
    logic              signed_q;
    logic              split_q;
    logic [XLEN-1:0]   beat0_q;

    op_info_t          req_info;
    logic [OFF_W-1:0]  req_off;
    logic [ADDR_W-1:0] req_base;
    logic [4:0]        req_span;
    logic              req_split;
    logic              req_illegal;
    logic              req_misalign;
    logic              req_skip;

    logic [XLEN-1:0]   ext_beat0;
    logic [XLEN-1:0]   ext_beat1;
    logic [XLEN-1:0]   ext_data;

    assign dbg_state = state_q;

    always_comb begin
        req_info    = op_info(req_op);
        req_off     = req_addr[OFF_W-1:0];
        req_base    = {req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
        req_illegal = (XLEN == 32) && (req_op == MEM_D);
        req_span    = 5'(req_off) + 5'(req_info.size);
        req_split   = req_span > 5'(WB);
`ifdef MISALIGN_TRAP_EN
        // Sizes are powers of two, so addr mod size is the low size-1 bits.
        req_misalign = (req_info.size != 4'd0) &&
                       ((req_addr[3:0] & (req_info.size - 4'd1)) != 4'd0);
`else
        req_misalign = 1'b0;
`endif
        req_skip = (req_op == MEM_NO) || req_illegal || req_misalign;

        // The result is registered on the cycle the last beat arrives, so the
        // arriving word is fed straight into the extractor. A single-beat load
        // sees an all-zero upper word.
        ext_beat0 = (state_q == ST_WAIT0) ? mem_resp_data : beat0_q;
        ext_beat1 = (state_q == ST_WAIT1) ? mem_resp_data : '0;
    end

    load_extract #(
        .XLEN (XLEN)
    ) u_extract (
        .beat0     (ext_beat0),
        .beat1     (ext_beat1),
        .offset    (off_q),
        .size      (size_q),
        .is_signed (signed_q),
        .data      (ext_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            base_q        <= '0;
            off_q         <= '0;
            size_q        <= '0;
            signed_q      <= 1'b0;
            split_q       <= 1'b0;
            beat0_q       <= '0;
            req_ready     <= 1'b0;
            mem_req_valid <= 1'b0;
            mem_req_addr  <= '0;
            resp_valid    <= 1'b0;
            resp_data     <= '0;
            resp_split    <= 1'b0;
            resp_fault    <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    req_ready <= 1'b1;
                    if (req_valid && req_ready) begin
                        req_ready <= 1'b0;
                        base_q    <= req_base;
                        off_q     <= req_off;
                        size_q    <= req_info.size;
                        signed_q  <= req_info.is_signed;
                        split_q   <= req_split;
                        beat0_q   <= '0;
                        if (req_skip) begin
                            state_q    <= ST_RESP;
                            resp_valid <= 1'b1;
                            resp_data  <= '0;
                            resp_split <= 1'b0;
                            resp_fault <= req_illegal || req_misalign;
                        end else begin
                            state_q       <= ST_REQ0;
                            mem_req_valid <= 1'b1;
                            mem_req_addr  <= req_base;
                        end
                    end
                end

                ST_REQ0: begin
                    if (mem_req_ready) begin
                        mem_req_valid <= 1'b0;
                        state_q       <= ST_WAIT0;
                    end
                end

                ST_WAIT0: begin
                    if (mem_resp_valid) begin
                        beat0_q <= mem_resp_data;
                        if (split_q) begin
                            state_q       <= ST_REQ1;
                            mem_req_valid <= 1'b1;
                            mem_req_addr  <= base_q + ADDR_W'(WB);
                        end else begin
                            state_q    <= ST_RESP;
                            resp_valid <= 1'b1;
                            resp_data  <= ext_data;
                            resp_split <= 1'b0;
                            resp_fault <= 1'b0;
                        end
                    end
                end

                ST_REQ1: begin
                    if (mem_req_ready) begin
                        mem_req_valid <= 1'b0;
                        state_q       <= ST_WAIT1;
                    end
                end

                ST_WAIT1: begin
                    if (mem_resp_valid) begin
                        state_q    <= ST_RESP;
                        resp_valid <= 1'b1;
                        resp_data  <= ext_data;
                        resp_split <= 1'b1;
                        resp_fault <= 1'b0;
                    end
                end

                ST_RESP: begin
                    if (resp_ready) begin
                        state_q    <= ST_IDLE;
                        resp_valid <= 1'b0;
                        resp_data  <= '0;
                        resp_split <= 1'b0;
                        resp_fault <= 1'b0;
                        req_ready  <= 1'b1;
                    end
                end

                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_load_align_unit.sv
// -----------------------------------------------------------------------------
// tb_load_align_unit
//   Self-checking bench for load_align_unit at XLEN=64. A word-addressed
//   memory model answers read requests one cycle after the request handshake.
//   Expected results come from a byte-level reference model. Honours
//   MISALIGN_TRAP_EN the same way the design does.
// -----------------------------------------------------------------------------
module tb_load_align_unit;
    import load_align_unit_pkg::*;

    localparam int XLEN   = 64;
    localparam int ADDR_W = 64;
    localparam int W      = 64;

`ifdef MISALIGN_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
    localparam logic [63:0] MID_ADDR = 64'h1008;
    localparam mem_op_enum  MID_OP   = MEM_D;
    localparam int          MID_CYC  = 2;
    localparam load_state_enum MID_STATE = ST_WAIT0;
`else
    localparam bit TRAP_EN = 1'b0;
    localparam logic [63:0] MID_ADDR = 64'h100C;
    localparam mem_op_enum  MID_OP   = MEM_D;
    localparam int          MID_CYC  = 4;
    localparam load_state_enum MID_STATE = ST_WAIT1;
`endif

    // ---------------- clock / reset / DUT ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr;
    mem_op_enum        req_op;
    logic              mem_req_valid;
    logic              mem_req_ready;
    logic [ADDR_W-1:0] mem_req_addr;
    logic              mem_resp_valid;
    logic [XLEN-1:0]   mem_resp_data;
    logic              resp_valid;
    logic              resp_ready;
    logic [XLEN-1:0]   resp_data;
    logic              resp_split;
    logic              resp_fault;
    load_state_enum    dbg_state;

    load_align_unit #(
        .XLEN   (XLEN),
        .ADDR_W (ADDR_W)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_addr       (req_addr),
        .req_op         (req_op),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_req_addr   (mem_req_addr),
        .mem_resp_valid (mem_resp_valid),
        .mem_resp_data  (mem_resp_data),
        .resp_valid     (resp_valid),
        .resp_ready     (resp_ready),
        .resp_data      (resp_data),
        .resp_split     (resp_split),
        .resp_fault     (resp_fault),
        .dbg_state      (dbg_state)
    );

    // ---------------- scoreboard state ----------------
    int total = 0;
    int bad   = 0;
    logic [W-1:0]  exp_q[$];
    logic [63:0]   req_log[$];
    logic [63:0]   mem[logic [63:0]];
    bit            mem_auto = 1'b1;

    function automatic logic [63:0] mem_word(input logic [63:0] a);
        if (mem.exists(a)) return mem[a];
        return (a * 64'h9E3779B97F4A7C15) ^ 64'h0123456789ABCDEF;
    endfunction

    function automatic logic [7:0] mem_byte(input logic [63:0] a);
        logic [63:0] w;
        w = mem_word({a[63:3], 3'b000});
        return 8'(w >> {a[2:0], 3'b000});
    endfunction

    // Reference: gather size bytes starting at a, little-endian, then extend.
    function automatic void ref_load(input logic [63:0] a, input mem_op_enum op,
                                     output logic [63:0] d, output logic sp,
                                     output logic ft, output int beats, output int lat);
        int size;
        bit sgn;
        logic [63:0] v;
        logic [63:0] mask;
        size = 0;
        sgn  = 1'b0;
        case (op)
            MEM_B:  begin size = 1; sgn = 1'b1; end
            MEM_H:  begin size = 2; sgn = 1'b1; end
            MEM_W:  begin size = 4; sgn = 1'b1; end
            MEM_D:  begin size = 8; sgn = 1'b1; end
            MEM_UB: size = 1;
            MEM_UH: size = 2;
            MEM_UW: size = 4;
            default: size = 0;
        endcase
        d = '0; sp = 1'b0; ft = 1'b0; beats = 0; lat = 1;
        if (size == 0) return;
        if (TRAP_EN && ((a % 64'(size)) != 64'd0)) begin
            ft = 1'b1;
            return;
        end
        v = '0;
        for (int i = 0; i < size; i++) v = v | (64'(mem_byte(a + 64'(i))) << (8 * i));
        mask = (size == 8) ? '1 : ((64'd1 << (8 * size)) - 64'd1);
        if (sgn && v[8 * size - 1]) v = v | ~mask;
        d     = v;
        sp    = (int'(a[2:0]) + size) > 8;
        beats = sp ? 2 : 1;
        lat   = sp ? 5 : 3;
    endfunction

    // ---------------- memory responder ----------------
    initial begin
        logic        hs;
        logic [63:0] a;
        forever begin
            @(negedge clk);
            hs = mem_req_valid && mem_req_ready && !rst;
            a  = mem_req_addr;
            if (hs) req_log.push_back(a);
            @(posedge clk);
            #1;
            if (mem_auto) begin
                mem_resp_valid = hs;
                mem_resp_data  = hs ? mem_word(a) : 64'h0;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send_req(input logic [63:0] a, input mem_op_enum op, output bit ok);
        req_addr  = a;
        req_op    = op;
        req_valid = 1'b1;
        ok        = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (req_ready) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_op    = MEM_NO;
        req_addr  = '0;
    endtask

    // Issue one load with resp_ready high; lat counts cycles from accept to resp_valid.
    task automatic run_load(input logic [63:0] a, input mem_op_enum op,
                            output logic [63:0] d, output logic sp, output logic ft,
                            output int lat, output bit ok);
        bit acc;
        send_req(a, op, acc);
        ok  = 1'b0;
        lat = 0;
        d   = '0; sp = 1'b0; ft = 1'b0;
        if (acc) begin
            for (int i = 0; i < 50; i++) begin
                @(negedge clk);
                lat++;
                if (resp_valid) begin
                    ok = 1'b1;
                    break;
                end
            end
            d  = resp_data;
            sp = resp_split;
            ft = resp_fault;
            @(posedge clk);
            #1;
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL reset_req_ready got=%0b want=0", req_ready); end
        total++; if (mem_req_valid !== 1'b0) begin bad++; $display("FAIL reset_mem_req_valid got=%0b want=0", mem_req_valid); end
        total++; if (resp_valid !== 1'b0) begin bad++; $display("FAIL reset_resp_valid got=%0b want=0", resp_valid); end
        total++; if (resp_data !== 64'h0) begin bad++; $display("FAIL reset_resp_data got=%h want=0", resp_data); end
        total++; if (dbg_state !== ST_IDLE) begin bad++; $display("FAIL reset_state got=%0d want=%0d", dbg_state, ST_IDLE); end
        rst = 1'b0;
        @(posedge clk);
        #1;
        total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL post_reset_req_ready got=%0b want=1", req_ready); end
    endtask

    task automatic test_directed();
        logic [63:0] a_v[3]   = '{64'h1004, 64'h1007, 64'h100C};
        mem_op_enum  op_v[3]  = '{MEM_W, MEM_UH, MEM_D};
        logic [63:0] d_v[3]   = '{64'hFFFFFFFF_80000001, 64'h00000000_0000CDAB, 64'h88776655_44332211};
        logic [63:0] m0_v[3]  = '{64'h1000, 64'h1000, 64'h1008};
        int          nb_v[3]  = '{1, 2, 2};
        int          n_vec;
        logic [63:0] d;
        logic        sp, ft;
        int          lat;
        bit          ok;
`ifdef MISALIGN_TRAP_EN
        n_vec = 1;
`else
        n_vec = 3;
`endif
        for (int v = 0; v < n_vec; v++) begin
            case (v)
                0: mem[64'h1000] = 64'h80000001_DEADBEEF;
                1: begin mem[64'h1000] = 64'hAB000000_00000000; mem[64'h1008] = 64'h00000000_000000CD; end
                default: begin mem[64'h1008] = 64'h44332211_00000000; mem[64'h1010] = 64'h00000000_88776655; end
            endcase
            req_log.delete();
            run_load(a_v[v], op_v[v], d, sp, ft, lat, ok);
            total++; if (!ok) begin bad++; $display("FAIL dir%0d_timeout got=no_resp want=resp", v); end
            total++; if (d !== d_v[v]) begin bad++; $display("FAIL dir%0d_data got=%h want=%h", v, d, d_v[v]); end
            total++; if (sp !== (nb_v[v] == 2)) begin bad++; $display("FAIL dir%0d_split got=%0b want=%0b", v, sp, nb_v[v] == 2); end
            total++; if (ft !== 1'b0) begin bad++; $display("FAIL dir%0d_fault got=%0b want=0", v, ft); end
            total++; if (lat != ((nb_v[v] == 2) ? 5 : 3)) begin bad++; $display("FAIL dir%0d_latency got=%0d want=%0d", v, lat, (nb_v[v] == 2) ? 5 : 3); end
            total++; if (req_log.size() != nb_v[v]) begin bad++; $display("FAIL dir%0d_beats got=%0d want=%0d", v, req_log.size(), nb_v[v]); end
            for (int b = 0; b < nb_v[v] && b < req_log.size(); b++) begin
                total++;
                if (req_log[b] !== m0_v[v] + 64'(8 * b)) begin
                    bad++; $display("FAIL dir%0d_addr%0d got=%h want=%h", v, b, req_log[b], m0_v[v] + 64'(8 * b));
                end
            end
        end
    endtask

    task automatic test_random();
        logic [63:0] a, d, ed, base;
        logic        sp, ft, esp, eft;
        int          lat, elat, eb;
        bit          ok;
        mem_op_enum  op;
        for (logic [63:0] w = 64'h2000; w <= 64'h2108; w += 64'd8)
            mem[w] = {$urandom(), $urandom()};
        for (int it = 0; it < 40; it++) begin
            if (it == 0) begin
                a  = 64'hFFFFFFFF_FFFFFFFE;   // straddles the top of the address space
                op = MEM_W;
            end else begin
                a  = 64'h2000 + 64'($urandom_range(0, 255));
                op = mem_op_enum'(3'($urandom_range(0, 7)));
            end
            ref_load(a, op, ed, esp, eft, eb, elat);
            exp_q.push_back(ed);
            req_log.delete();
            run_load(a, op, d, sp, ft, lat, ok);
            total++; if (!ok) begin bad++; $display("FAIL rnd%0d_timeout addr=%h op=%0d got=no_resp want=resp", it, a, op); end
            ed = exp_q.pop_front();
            total++; if (d !== ed) begin bad++; $display("FAIL rnd%0d_data addr=%h op=%0d got=%h want=%h", it, a, op, d, ed); end
            total++; if (sp !== esp) begin bad++; $display("FAIL rnd%0d_split addr=%h op=%0d got=%0b want=%0b", it, a, op, sp, esp); end
            total++; if (ft !== eft) begin bad++; $display("FAIL rnd%0d_fault addr=%h op=%0d got=%0b want=%0b", it, a, op, ft, eft); end
            total++; if (lat != elat) begin bad++; $display("FAIL rnd%0d_latency addr=%h op=%0d got=%0d want=%0d", it, a, op, lat, elat); end
            total++; if (req_log.size() != eb) begin bad++; $display("FAIL rnd%0d_beats addr=%h op=%0d got=%0d want=%0d", it, a, op, req_log.size(), eb); end
            base = {a[63:3], 3'b000};
            for (int b = 0; b < eb && b < req_log.size(); b++) begin
                total++;
                if (req_log[b] !== base + 64'(8 * b)) begin
                    bad++; $display("FAIL rnd%0d_addr%0d got=%h want=%h", it, b, req_log[b], base + 64'(8 * b));
                end
            end
        end
    endtask

    task automatic test_backpressure();
        bit ok;
        int n;
        mem[64'h1000] = 64'h80000001_DEADBEEF;
        req_log.delete();
        mem_req_ready = 1'b0;
        resp_ready    = 1'b0;
        send_req(64'h1004, MEM_W, ok);
        total++; if (!ok) begin bad++; $display("FAIL bp_accept got=0 want=1"); end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            total++; if (mem_req_valid !== 1'b1 || mem_req_addr !== 64'h1000) begin
                bad++; $display("FAIL bp_req_hold%0d got=%0b/%h want=1/%h", i, mem_req_valid, mem_req_addr, 64'h1000);
            end
            total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL bp_req_ready%0d got=%0b want=0", i, req_ready); end
        end
        @(posedge clk);
        #1;
        mem_req_ready = 1'b1;
        n = 0;
        while (!resp_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        total++; if (resp_valid !== 1'b1) begin bad++; $display("FAIL bp_resp_timeout got=%0b want=1", resp_valid); end
        for (int i = 0; i < 4; i++) begin
            if (i > 0) @(negedge clk);
            total++; if (resp_valid !== 1'b1 || resp_data !== 64'hFFFFFFFF_80000001) begin
                bad++; $display("FAIL bp_resp_hold%0d got=%0b/%h want=1/%h", i, resp_valid, resp_data, 64'hFFFFFFFF_80000001);
            end
            total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL bp_resp_req_ready%0d got=%0b want=0", i, req_ready); end
        end
        @(posedge clk);
        #1;
        resp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        total++; if (resp_valid !== 1'b0) begin bad++; $display("FAIL bp_resp_drop got=%0b want=0", resp_valid); end
        total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL bp_idle_ready got=%0b want=1", req_ready); end
        total++; if (req_log.size() != 1) begin bad++; $display("FAIL bp_beats got=%0d want=1", req_log.size()); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_midop();
        bit          ok;
        logic [63:0] d;
        logic        sp, ft;
        int          lat;
        mem[64'h1008] = 64'h44332211_00000000;
        mem[64'h1010] = 64'h00000000_88776655;
        mem[64'h1000] = 64'h80000001_DEADBEEF;
        send_req(MID_ADDR, MID_OP, ok);
        total++; if (!ok) begin bad++; $display("FAIL mid_accept got=0 want=1"); end
        repeat (MID_CYC) @(negedge clk);
        total++; if (dbg_state !== MID_STATE) begin bad++; $display("FAIL mid_state got=%0d want=%0d", dbg_state, MID_STATE); end
        rst            = 1'b1;
        mem_auto       = 1'b0;
        mem_resp_valid = 1'b0;
        mem_resp_data  = '0;
        #1;
        total++; if (mem_req_valid !== 1'b0 || resp_valid !== 1'b0 || req_ready !== 1'b0) begin
            bad++; $display("FAIL mid_rst_outputs got=%0b%0b%0b want=000", mem_req_valid, resp_valid, req_ready);
        end
        total++; if (resp_data !== 64'h0) begin bad++; $display("FAIL mid_rst_data got=%h want=0", resp_data); end
        total++; if (dbg_state !== ST_IDLE) begin bad++; $display("FAIL mid_rst_state got=%0d want=%0d", dbg_state, ST_IDLE); end
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        mem_resp_valid = 1'b1;
        mem_resp_data  = 64'hFFFFFFFF_FFFFFFFF;
        @(posedge clk);
        #1;
        mem_resp_valid = 1'b0;
        mem_resp_data  = '0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            total++; if (resp_valid !== 1'b0 || mem_req_valid !== 1'b0) begin
                bad++; $display("FAIL mid_late_resp%0d got=%0b/%0b want=0/0", i, resp_valid, mem_req_valid);
            end
        end
        total++; if (dbg_state !== ST_IDLE || req_ready !== 1'b1) begin
            bad++; $display("FAIL mid_idle got=%0d/%0b want=%0d/1", dbg_state, req_ready, ST_IDLE);
        end
        mem_auto = 1'b1;
        @(posedge clk);
        #1;
        run_load(64'h1004, MEM_W, d, sp, ft, lat, ok);
        total++; if (!ok || d !== 64'hFFFFFFFF_80000001) begin
            bad++; $display("FAIL mid_recover got=%0b/%h want=1/%h", ok, d, 64'hFFFFFFFF_80000001);
        end
    endtask

    task automatic test_trap();
        logic [63:0] d;
        logic        sp, ft;
        int          lat;
        bit          ok;
        mem[64'h1000] = 64'h11223344_55667788;
        req_log.delete();
        run_load(64'h1001, MEM_H, d, sp, ft, lat, ok);
        total++; if (!ok) begin bad++; $display("FAIL trap_timeout got=no_resp want=resp"); end
`ifdef MISALIGN_TRAP_EN
        total++; if (ft !== 1'b1) begin bad++; $display("FAIL trap_fault got=%0b want=1", ft); end
        total++; if (d !== 64'h0) begin bad++; $display("FAIL trap_data got=%h want=0", d); end
        total++; if (req_log.size() != 0) begin bad++; $display("FAIL trap_beats got=%0d want=0", req_log.size()); end
        total++; if (lat != 1) begin bad++; $display("FAIL trap_latency got=%0d want=1", lat); end
`else
        total++; if (ft !== 1'b0) begin bad++; $display("FAIL trap_fault got=%0b want=0", ft); end
        total++; if (d !== 64'h0000000000006677) begin bad++; $display("FAIL trap_data got=%h want=%h", d, 64'h6677); end
        total++; if (req_log.size() != 1) begin bad++; $display("FAIL trap_beats got=%0d want=1", req_log.size()); end
        total++; if (sp !== 1'b0 || lat != 3) begin bad++; $display("FAIL trap_split_lat got=%0b/%0d want=0/3", sp, lat); end
`endif
    endtask

    // ---------------- main sequence ----------------
    initial begin
        req_valid      = 1'b0;
        req_addr       = '0;
        req_op         = MEM_NO;
        mem_req_ready  = 1'b1;
        mem_resp_valid = 1'b0;
        mem_resp_data  = '0;
        resp_ready     = 1'b1;

        test_reset();
        test_directed();
        test_backpressure();
        test_trap();
        test_random();
        test_reset_midop();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/load_align_unit.md
Name: load_align_unit

Overview:
- Parametrised load-path successor to the core's load data truncation logic.
- Accepts one load (address + CorePack::mem_op_enum) and fetches the aligned memory word(s).
- Supports loads that straddle a word boundary by issuing two beats, then extracts and sign/zero-extends the result.
- Sits between the MEM stage and the data-memory port; uses valid/ready on all three interfaces.

Parameters:
- XLEN, 64, data/word width in bits (32 or 64); bytes per word WB = XLEN/8.
- ADDR_W, 64, address width in bits.

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous, active-high reset
- req_valid  in  1  load request valid
- req_ready  out  1  unit can accept a request (high only in IDLE)
- req_addr  in  ADDR_W  byte address of load
- req_op  in  mem_op_enum  load type (MEM_B/H/W/D/UB/UH/UW/NO)
- mem_req_valid  out  1  memory read request valid
- mem_req_ready  in  1  memory accepts request
- mem_req_addr  out  ADDR_W  word-aligned read address
- mem_resp_valid  in  1  memory read data valid
- mem_resp_data  in  XLEN  memory read data
- resp_valid  out  1  result valid
- resp_ready  in  1  consumer accepts result
- resp_data  out  XLEN  extended load result
- resp_split  out  1  result required two memory beats
- resp_fault  out  1  illegal op (MEM_D when XLEN=32) or trapped misalignment

Behaviour:
- States: IDLE, REQ0, WAIT0, REQ1, WAIT1, RESP.
- Reset: async to IDLE; all outputs and internal registers 0; req_ready is 0 while rst is high and 1 in the first cycle after release.
- IDLE -> REQ0 on req_valid&&req_ready; latch addr, op, offset = addr[log2(WB)-1:0], size (B=1, H=2, W=4, D=8). MEM_NO and illegal ops skip memory and go IDLE -> RESP with data 0 (fault=1 for illegal).
- Split condition: offset+size > WB.
- REQ0: mem_req_valid=1, mem_req_addr = addr with low log2(WB) bits cleared; on mem_req_ready -> WAIT0.
- WAIT0: on mem_resp_valid, latch beat0; -> REQ1 if split, else -> RESP.
- REQ1: address = aligned+WB (wraps modulo 2^ADDR_W); on handshake -> WAIT1.
- WAIT1: on mem_resp_valid, latch beat1 -> RESP.
- RESP: resp_valid=1; resp_data/split/fault held stable until resp_ready; then -> IDLE. No same-cycle re-accept, so minimum occupancy is one idle cycle per load.
- Extraction: window = {beat1,beat0} >> (offset*8); take low size*8 bits. Signed ops replicate bit size*8-1; MEM_UB/UH/UW zero-fill.
- Latency, aligned load with 0-wait memory: resp_valid 3 cycles after accept. Split load: 5 cycles.
- mem_resp_valid outside WAIT0/WAIT1 is ignored. Request outputs stay stable while waiting for ready.
- Reset mid-operation abandons the transaction; a late memory response is dropped.

Optional Feature:
- MISALIGN_TRAP_EN defined: a request with addr mod size != 0 issues no memory beat and goes directly to RESP with resp_fault=1, resp_data=0.
- Undefined: misaligned loads are serviced, split if required. Aligned behaviour is identical in both builds.

Decomposition:
- CorePack holds load_state_enum (6 states) and a function mapping mem_op_enum to size in bytes plus a signed flag. mem_op_enum is reused unchanged.
- One combinational sub-module, load_extract (window shift + extend, parametrised by XLEN), is instantiated once.

Test Plan (XLEN=64):
- Aligned sign extension: LW @0x1004, word@0x1000=0x80000001_DEADBEEF -> resp_data=0xFFFFFFFF_80000001, split=0, one mem_req_addr=0x1000.
- Split halfword: LHU @0x1007, word@0x1000 byte7=0xAB, word@0x1008 byte0=0xCD -> mem addrs 0x1000 then 0x1008; resp_data=0x000000000000CDAB, split=1.
- Split doubleword: LD @0x100C, word@0x1008=0x44332211_00000000, word@0x1010=0x00000000_88776655 -> resp_data=0x88776655_44332211.
- Backpressure: mem_req_ready low 3 cycles, then resp_ready low 4 cycles -> mem_req_addr and resp_data stable, req_ready=0 throughout, exactly one memory request issued per beat.
- Reset mid-op: assert rst in WAIT1, then pulse mem_resp_valid after release -> outputs 0 immediately, unit in IDLE, no resp_valid.
- Build with MISALIGN_TRAP_EN: LH @0x1001 -> no mem_req_valid, resp_fault=1, resp_data=0. Without the macro, same load -> one beat, resp_fault=0.
